// File: rtl/tc_stage_pkg.sv
// Shared types and defaults for the tensor-core operand staging path.
package tc_stage_pkg;

  localparam int TC_WORD_WIDTH = 32;
  localparam int TC_ROW_LEN    = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    OUT  = 1'b1
  } packer_state_t;

endpackage

// File: rtl/operand_row_packer.sv
// Pops operand words from the FIFO and packs ROW_LEN of them into one row;
// a flush closes a partial row with zero padding.
//
// state | meaning
// FILL  | popping words from the buffer and latching them into lanes
// OUT   | row presented on row_valid, waiting for row_ready; no pops
module operand_row_packer
  import tc_stage_pkg::*;
#(
  parameter int WIDTH   = TC_WORD_WIDTH,
  parameter int ROW_LEN = TC_ROW_LEN
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     buf_empty,
  input  logic [WIDTH-1:0]         buf_dout,
  output logic                     buf_read_en,
  input  logic                     flush_req,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [ROW_LEN*WIDTH-1:0] row_data,
  output logic                     row_partial
);

  localparam int CW = $clog2(ROW_LEN + 1);
  localparam int IW = $clog2(ROW_LEN);
  localparam logic [CW-1:0] FULL_CNT = CW'(ROW_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  packer_state_t    state;
  logic [CW-1:0]    issued;
  logic [CW-1:0]    captured;
  logic             inflight;
  logic             partial_q;
  logic [WIDTH-1:0] lanes [ROW_LEN];

  // RST gates the pop so a word is never lost to a buffer read in the reset cycle.
  assign buf_read_en = (state == FILL) && !buf_empty && (issued < FULL_CNT)
                       && !flush_req && !RST;
  assign row_valid   = (state == OUT);
  assign row_partial = partial_q;

  always_comb begin
    row_data = '0;
    for (int k = 0; k < ROW_LEN; k++) begin
      row_data[k*WIDTH +: WIDTH] = lanes[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FILL;
      issued    <= '0;
      captured  <= '0;
      inflight  <= 1'b0;
      partial_q <= 1'b0;
      for (int k = 0; k < ROW_LEN; k++) begin
        lanes[k] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          inflight <= buf_read_en;
          if (buf_read_en) begin
            issued <= issued + ONE_CNT;
          end
          // A pending capture wins over flush, so a flush that lands on the
          // final word still yields a full, non-partial row.
          if (inflight) begin
            lanes[captured[IW-1:0]] <= buf_dout;
            captured <= captured + ONE_CNT;
            if (captured == LAST_CNT) begin
              partial_q <= 1'b0;
              state     <= OUT;
            end
          end else if (flush_req && (captured != '0)) begin
            for (int k = 0; k < ROW_LEN; k++) begin
              if (CW'(k) >= captured) begin
                lanes[k] <= '0;
              end
            end
            partial_q <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          inflight <= 1'b0;
          if (row_ready) begin
            issued    <= '0;
            captured  <= '0;
            partial_q <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_row_packer.sv
// Directed bench for operand_row_packer: behavioural FIFO with 1-cycle read
// latency, vector table of rows, plus hand sequences for timing corners.
module tb_operand_row_packer;
  import tc_stage_pkg::*;

  localparam int W = 32;
  localparam int R = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           buf_empty;
  logic [W-1:0]   buf_dout;
  logic           buf_read_en;
  logic           flush_req;
  logic           row_valid;
  logic           row_ready;
  logic [R*W-1:0] row_data;
  logic           row_partial;

  operand_row_packer #(.WIDTH(W), .ROW_LEN(R)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .buf_empty  (buf_empty),
    .buf_dout   (buf_dout),
    .buf_read_en(buf_read_en),
    .flush_req  (flush_req),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_partial(row_partial)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_total = 0;
  int first_pop_cyc = -1;
  int last_pop_cyc = -1;
  int first_valid_cyc = -1;
  bit gap_en = 1'b0;
  bit gap_phase = 1'b0;
  bit hold = 1'b0;
  logic [R*W-1:0] held;

  logic [W-1:0]   q[$];
  logic [R*W-1:0] rq_data[$];
  logic           rq_part[$];

  typedef struct {
    int             n;
    logic [R*W-1:0] words;
    bit             gap;
    bit             flush;
    logic [R*W-1:0] exp;
    bit             exp_p;
  } vec_t;

  vec_t vecs[5];

  // FIFO model: registered read, word appears the cycle after the pop.
  always @(posedge CLK) begin
    if (buf_read_en) begin
      if (q.size() > 0) buf_dout <= q.pop_front();
      pop_total++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (buf_read_en) begin
        checks++;
        if (buf_empty) begin
          errors++;
          $display("FAIL underflow_pop cyc=%0d buf_read_en=1 while buf_empty=1", cyc);
        end
      end
      if (row_valid) begin
        checks++;
        if (buf_read_en) begin
          errors++;
          $display("FAIL pop_in_out cyc=%0d buf_read_en=%0b required 0", cyc, buf_read_en);
        end
        if (hold && row_data !== held) begin
          errors++;
          $display("FAIL row_stable cyc=%0d got %h required %h", cyc, row_data, held);
        end
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        held = row_data;
        hold = !row_ready;
        if (row_ready) begin
          rq_data.push_back(row_data);
          rq_part.push_back(row_partial);
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic upd_empty();
    buf_empty = (q.size() == 0) || (gap_en && gap_phase);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    gap_phase = ~gap_phase;
    upd_empty();
  endtask

  task automatic push(input logic [W-1:0] w);
    q.push_back(w);
    upd_empty();
  endtask

  task automatic chk(input string name, input logic [R*W-1:0] got, input logic [R*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_rows(input string name, input int n, input int budget);
    int b;
    b = 0;
    while (rq_data.size() < n && b < budget) begin
      step();
      b++;
    end
    checks++;
    if (rq_data.size() < n) begin
      errors++;
      $display("FAIL %s_timeout rows=%0d required %0d", name, rq_data.size(), n);
    end
  endtask

  task automatic check_row(input string name, input logic [R*W-1:0] exp, input logic exp_p);
    checks++;
    if (rq_data.size() == 0) begin
      errors++;
      $display("FAIL %s_row no row captured, required %h", name, exp);
    end else begin
      logic [R*W-1:0] d;
      logic p;
      d = rq_data.pop_front();
      p = rq_part.pop_front();
      if (d !== exp || p !== exp_p) begin
        errors++;
        $display("FAIL %s_row got %h partial %0b required %h partial %0b", name, d, p, exp, exp_p);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0};
    vecs[1] = '{2, {32'd0, 32'd0, 32'd9, 32'd7}, 1'b0, 1'b1, {32'd0, 32'd0, 32'd9, 32'd7}, 1'b1};
    vecs[2] = '{4, {32'h1, 32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF}, 1'b0, 1'b0,
                {32'h1, 32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF}, 1'b0};
    vecs[3] = '{1, {32'd0, 32'd0, 32'd0, 32'd42}, 1'b0, 1'b1, {32'd0, 32'd0, 32'd0, 32'd42}, 1'b1};
    vecs[4] = '{3, {32'd0, 32'd33, 32'd22, 32'd11}, 1'b0, 1'b1, {32'd0, 32'd33, 32'd22, 32'd11}, 1'b1};

    RST = 1'b1; flush_req = 1'b0; row_ready = 1'b0; buf_dout = '0;
    push(32'd100); push(32'd200); push(32'd300); push(32'd400);

    // Reset held two cycles with the buffer non-empty.
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge CLK);
      chk("reset_read_en", {127'd0, buf_read_en}, '0);
      chk("reset_valid", {127'd0, row_valid}, '0);
      chk("reset_data", row_data, '0);
    end

    // Full row: first pop in cycle c0, valid in c0+5.
    step();
    RST = 1'b0; row_ready = 1'b1;
    p0 = cyc;
    first_pop_cyc = -1; first_valid_cyc = -1;
    wait_rows("full", 1, 20);
    check_row("full", {32'd400, 32'd300, 32'd200, 32'd100}, 1'b0);
    chk("full_pops", pop_total, 4);
    chk("full_first_pop", first_pop_cyc, p0);
    chk("full_last_pop", last_pop_cyc, p0 + 3);
    chk("full_valid_cyc", first_valid_cyc, p0 + 5);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      gap_en = vecs[v].gap;
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].words[k*W +: W]);
      if (vecs[v].flush) begin
        for (int s = 0; s < vecs[v].n + 3; s++) step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
      end
      wait_rows($sformatf("vec%0d", v), 1, 30);
      check_row($sformatf("vec%0d", v), vecs[v].exp, vecs[v].exp_p);
      gap_en = 1'b0;
      upd_empty();
      step();
    end

    // Flush with nothing captured emits no row.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int s = 0; s < 8; s++) step();
    chk("empty_flush_rows", rq_data.size(), 0);
    @(negedge CLK);
    chk("empty_flush_valid", {127'd0, row_valid}, '0);
    step();

    // Backpressure: second row must survive a long stall on the first.
    row_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push(32'(k * 10));
    begin
      int b;
      b = 0;
      while (!row_valid && b < 20) begin step(); b++; end
      chk("bp_valid_seen", {127'd0, row_valid}, {127'd0, 1'b1});
    end
    begin
      int pops_at_valid;
      pops_at_valid = pop_total;
      for (int s = 0; s < 6; s++) step();
      chk("bp_no_pops", pop_total, pops_at_valid);
      chk("bp_data", row_data, {32'd40, 32'd30, 32'd20, 32'd10});
    end
    row_ready = 1'b1;
    wait_rows("bp", 2, 30);
    check_row("bp_first", {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
    check_row("bp_second", {32'd80, 32'd70, 32'd60, 32'd50}, 1'b0);
    step();

    // Flush coincides with the final capture: full, non-partial row.
    push(32'd501); push(32'd502); push(32'd503); push(32'd504);
    for (int s = 0; s < 4; s++) step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    wait_rows("flush_last", 1, 20);
    check_row("flush_last", {32'd504, 32'd503, 32'd502, 32'd501}, 1'b0);
    step();

    // Reset mid-fill discards captured lanes.
    push(32'd91); push(32'd92);
    for (int s = 0; s < 4; s++) step();
    RST = 1'b1;
    step();
    @(negedge CLK);
    chk("midrst_valid", {127'd0, row_valid}, '0);
    chk("midrst_data", row_data, '0);
    q.delete();
    RST = 1'b0;
    upd_empty();
    push(32'd5); push(32'd6); push(32'd7); push(32'd8);
    wait_rows("midrst", 1, 20);
    check_row("midrst", {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);

    for (int s = 0; s < 3; s++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
